// File: rtl/ppu_bg_fetch.sv
// Purpose : 2C02 background tile fetch sequencer; walks loopy v over a scanline run and
//           issues NT / AT / pattern-lo / pattern-hi reads on the 14-bit PPU bus.
// Latency : line_start in cycle C -> first NT address in C+1; one tile strobe every 8 cycles.
// Backpr. : none; the responder must return read data one cycle after the address.
//           line_start and v_load are ignored while busy.
// Ports   : clk, rst (async, active low)
//           line_start, v_load, v_i, t_i, bg_table  - run control and loopy registers
//           data_i / addr / rw                      - memory map read port (read only)
//           tile_valid, tile_lo, tile_hi, tile_attr - completed tile to the shifters
//           busy, v_o                               - run in progress, current v
module ppu_bg_fetch #(
   parameter int TILES = 34
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        line_start,
   input  logic        v_load,
   input  logic [14:0] v_i,
   input  logic [14:0] t_i,
   input  logic        bg_table,
   input  logic [7:0]  data_i,
   output logic [13:0] addr,
   output logic        rw,
   output logic        tile_valid,
   output logic [7:0]  tile_lo,
   output logic [7:0]  tile_hi,
   output logic [1:0]  tile_attr,
   output logic        busy,
   output logic [14:0] v_o
);

   localparam int TW = $clog2(TILES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WRAP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    phase;
   logic [TW-1:0] tile;
   logic [14:0]   v;
   logic [7:0]    nt;
   logic [1:0]    at;
   logic [7:0]    lo;

   logic          last_tile;
   logic [14:0]   v_start;
   logic [14:0]   v_incx;

   // Only t[10] and t[4:0] take part in the horizontal copy.
   logic          unused_t;
   assign unused_t = ^{t_i[14:11], t_i[9:5]};

   // ---------------------------------------------------------------
   // Address and loopy-v helpers
   // ---------------------------------------------------------------
   function automatic logic [13:0] nt_addr(input logic [14:0] vv);
      return {2'b10, vv[11:0]};
   endfunction

   // 0x23C0 | nametable select | coarse Y / 4 | coarse X / 4
   function automatic logic [13:0] at_addr(input logic [14:0] vv);
      return {2'b10, vv[11:10], 4'b1111, vv[9:7], vv[4:2]};
   endfunction

   // bg_table<<12 | tile index<<4 | plane<<3 | fine Y
   function automatic logic [13:0] pt_addr(input logic tbl, input logic [7:0] idx,
                                           input logic plane, input logic [2:0] fy);
      return {1'b0, tbl, idx, plane, fy};
   endfunction

   function automatic logic [14:0] inc_x(input logic [14:0] vv);
      logic [14:0] r;
      r = vv;
      if (r[4:0] == 5'd31) begin
         r[4:0] = 5'd0;
         r[10]  = ~r[10];
      end else begin
         r[4:0] = r[4:0] + 5'd1;
      end
      return r;
   endfunction

   // Fine-Y increment followed by the horizontal copy from t.
   function automatic logic [14:0] end_of_line(input logic [14:0] vv, input logic [14:0] tt);
      logic [14:0] r;
      r = vv;
      if (r[14:12] != 3'd7) begin
         r[14:12] = r[14:12] + 3'd1;
      end else begin
         r[14:12] = 3'd0;
         if (r[9:5] == 5'd29) begin
            // last visible tile row: wrap and switch vertical nametable
            r[9:5] = 5'd0;
            r[11]  = ~r[11];
         end else if (r[9:5] == 5'd31) begin
            // rows 30/31 sit in attribute space; wrap without a nametable flip
            r[9:5] = 5'd0;
         end else begin
            r[9:5] = r[9:5] + 5'd1;
         end
      end
      r[10]  = tt[10];
      r[4:0] = tt[4:0];
      return r;
   endfunction

   assign v_start = v_load ? v_i : v;
   assign v_incx  = inc_x(v);

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      last_tile = (tile == TW'(TILES - 1));
      case (state)
         S_IDLE:  if (line_start) state_nxt = S_FETCH;
         S_FETCH: if (phase == 3'd7 && last_tile) state_nxt = S_WRAP;
         S_WRAP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // ---------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr       <= 14'd0;
         phase      <= 3'd0;
         tile       <= '0;
         v          <= 15'd0;
         nt         <= 8'd0;
         at         <= 2'd0;
         lo         <= 8'd0;
         tile_valid <= 1'b0;
         tile_lo    <= 8'd0;
         tile_hi    <= 8'd0;
         tile_attr  <= 2'd0;
      end else begin
         tile_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (v_load) v <= v_i;
               if (line_start) begin
                  addr  <= nt_addr(v_start);
                  phase <= 3'd0;
                  tile  <= '0;
               end
            end
            S_FETCH: begin
               phase <= phase + 3'd1;
               // Data for the address issued on the even phase arrives on the odd
               // phase; capture it and present the next address on the same edge.
               case (phase)
                  3'd1: begin
                     nt   <= data_i;
                     addr <= at_addr(v);
                  end
                  3'd3: begin
                     // quadrant select {coarse Y bit 1, coarse X bit 1} picks the 2-bit field
                     at   <= {data_i[{v[6], v[1], 1'b1}], data_i[{v[6], v[1], 1'b0}]};
                     addr <= pt_addr(bg_table, nt, 1'b0, v[14:12]);
                  end
                  3'd5: begin
                     lo   <= data_i;
                     addr <= pt_addr(bg_table, nt, 1'b1, v[14:12]);
                  end
                  3'd7: begin
                     tile_valid <= 1'b1;
                     tile_lo    <= lo;
                     tile_hi    <= data_i;
                     tile_attr  <= at;
                     v          <= v_incx;
                     if (!last_tile) begin
                        addr <= nt_addr(v_incx);
                        tile <= tile + TW'(1);
                     end
                  end
                  default: ;
               endcase
            end
            S_WRAP: begin
               v <= end_of_line(v, t_i);
            end
            default: ;
         endcase
      end
   end

   assign rw   = 1'b1;
   assign busy = (state != S_IDLE);
   assign v_o  = v;

endmodule

// File: doc/ppu_bg_fetch.md
# ppu_bg_fetch

Background tile fetch sequencer for the 2C02 PPU: the initiator on the PPU memory bus whose responder is the PPU memory map (pattern/CHR memory plus nametable VRAM). Per scanline run it walks the loopy `v` register, issuing nametable, attribute, pattern-low and pattern-high reads on the 14-bit bus. It delivers one complete tile (two pattern bytes plus a 2-bit palette select) every 8 cycles to the background shifters. After each run it performs the fine-Y increment and the horizontal copy from `t`.

## Interface
- `TILES`, 34: tiles fetched per run (2 prefetch + 32 visible).
- `clk` in 1: PPU dot clock, one dot per cycle.
- `rst` in 1: asynchronous, active-low reset.
- `line_start` in 1: single-cycle pulse that starts a run; honoured only in IDLE.
- `v_load` in 1: load `v` from `v_i`; honoured only in IDLE.
- `v_i` in 15: value loaded into `v` (vertical copy / $2006 path).
- `t_i` in 15: loopy `t`; bits [10] and [4:0] are used for the horizontal copy.
- `bg_table` in 1: background pattern table select (PPUCTRL bit 4).
- `data_i` in 8: read data from the memory map.
- `addr` out 14: registered bus address.
- `rw` out 1: constant 1 (read); this block never writes.
- `tile_valid` out 1: single-cycle strobe; tile outputs are valid while it is high.
- `tile_lo`, `tile_hi` out 8: pattern bytes of the completed tile.
- `tile_attr` out 2: palette select of the completed tile.
- `busy` out 1: high in FETCH and WRAP.
- `v_o` out 15: current `v`.

## Operation
- States: IDLE, FETCH, WRAP.
- IDLE→FETCH on `line_start`. FETCH→WRAP after phase 7 of tile `TILES-1`. WRAP→IDLE unconditionally after 1 cycle.
- `v_load` and `line_start` in the same IDLE cycle: `v`←`v_i` and the run starts from `v_i`.
- In FETCH, a 3-bit phase counter and a tile counter (0..`TILES-1`) are active. Each read holds `addr` for 2 phases.
  - Phases 0–1: NT read, `addr` = 0x2000 | v[11:0]; capture `nt`.
  - Phases 2–3: AT read, `addr` = 0x23C0 | v[11:10]<<10 | v[9:7]<<3 | v[4:2]. Capture `at` = (data_i >> {v[6],v[1],1'b0})[1:0].
  - Phases 4–5: pattern-low read, `addr` = bg_table<<12 | nt<<4 | v[14:12]; capture `lo`.
  - Phases 6–7: pattern-high read, same address + 8; capture `hi`.
- Capture happens on the clock edge that ends the odd phase of each pair. This matches the responder's 1-cycle registered read: address is registered in cycle N, data is valid in cycle N+1.
- On the edge ending phase 7, coarse-X increment:
  - if v[4:0]==31: v[4:0]←0 and v[10] inverts;
  - else v[4:0]+1.
- WRAP (single cycle), fine-Y increment:
  - if v[14:12]<7: v[14:12]+1;
  - else v[14:12]←0, then on coarse Y (v[9:5]): 29 → 0 with v[11] inverted; 31 → 0 with no flip; otherwise +1.
- Also in WRAP, horizontal copy: v[10]←t_i[10], v[4:0]←t_i[4:0]. The horizontal copy is applied after the Y increment.
- `line_start` and `v_load` are ignored while `busy`.
- All arithmetic wraps within field width; there is no carry out of any field.

## Timing
- Reset values: `addr`=0, `rw`=1, `tile_valid`=0, `tile_lo`=`tile_hi`=0, `tile_attr`=0, `busy`=0, `v`=0, state IDLE, counters 0.
- `line_start` sampled high in cycle C → `busy`=1 and the first NT address are on `addr` in cycle C+1.
- `tile_valid` is high for exactly the cycle after phase 7 of each tile, concurrent with the next tile's phase 0. For the last tile it coincides with WRAP.
- Run length: 8×`TILES` FETCH cycles + 1 WRAP cycle. `busy` falls in the cycle after WRAP. The earliest accepted next `line_start` is in that cycle.
- `addr` holds its last value in IDLE.
- `v_o` updates on the edge after each increment or load.
- Reset asserted mid-run takes effect immediately: all outputs go to reset values and no partial tile is strobed.

## Test plan
- v=0, bg_table=0, memory model returns NT=0x24 and pattern bytes 0xA5/0x5A, `TILES`=34: `addr` sequence 0x2000,0x2000,0x23C0,0x23C0,0x0240,0x0240,0x0248,0x0248. Then `tile_valid` with `tile_lo`=0xA5, `tile_hi`=0x5A; total `busy` = 273 cycles.
- Attribute select: v coarse X=2, coarse Y=2, AT byte 0xC0 → AT `addr` 0x23C0 and `tile_attr`=3. With coarse X=0, coarse Y=0 → `tile_attr`=0.
- Coarse-X wrap: v=0x001F → second tile NT `addr` = 0x2400.
- Y wrap: v_i=0x73A0 (fine Y 7, coarse Y 29), t_i=0x0405, run → `v_o`=0x0C05 after WRAP.
- `line_start` pulsed mid-run and `v_load` during WRAP → both ignored; exactly `TILES` tile strobes occur.
- `rst` low at tile 5 phase 3 → outputs return to reset values immediately; a new `line_start` restarts cleanly from `v`=0.
